mem_access_memwb: RTL and testbench

//   Consumer end of the EX/MEM pipeline register. Issues loads/stores from EX/MEM to a multi-cycle

---
 rtl/mem_access_memwb.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_memwb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_memwb.sv
// -----------------------------------------------------------------------------
// mem_access_memwb
//
// Memory-access stage of the pipeline. It consumes the EX/MEM register and
// issues loads and stores to a multi-cycle data memory over a req/ready
// handshake. It also owns the MEM/WB register that feeds writeback.
//
// While a request is outstanding (req high, ready low), mem_stall freezes
// EX/MEM and every stage upstream of it, and a bubble is pushed into MEM/WB.
// Store data is forwarded from the instruction currently in WB. When a request
// has to wait, its address, direction and data are latched, so a change on the
// WB bus during the stall cannot corrupt the store.
//
// State table
//   state | meaning
//   IDLE  | no request held; a new access is issued combinationally from EX/MEM
//   WAIT  | request outstanding; latched addr/we/wdata are driven until ready
//   HALT  | Halt reached MEM/WB; memory port quiesced until reset
//
// Ports
//   clk, rst                         clock (rising edge), async active-high reset
//   exm_mem_rd, exm_mem_wr           EX/MEM memory controls (both set = store)
//   exm_wb                           EX/MEM WB ctrl {RegWrite,MemtoReg,PCtoReg,Halt}
//   exm_alu, exm_store               address / ALU result, pre-forwarding store data
//   exm_dst, exm_src2, exm_pc        destination reg, store-data source reg, PC+2
//   wb_regwrite, wb_dst, wb_data     instruction in WB, used for store forwarding
//   dmem_req/we/addr/wdata           request to the data memory
//   dmem_ready, dmem_rdata           completion and load data from the memory
//   mem_stall                        freeze EX/MEM and upstream this cycle
//   mw_wb/mem_data/alu/dst/pc        MEM/WB register
//   halted                           Halt is in MEM/WB or beyond; no more accesses
//   stall_cnt                        saturating count of mem_stall cycles
// -----------------------------------------------------------------------------
module mem_access_memwb #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exm_mem_rd,
    input  logic              exm_mem_wr,
    input  logic [3:0]        exm_wb,
    input  logic [DATA_W-1:0] exm_alu,
    input  logic [DATA_W-1:0] exm_store,
    input  logic [REG_W-1:0]  exm_dst,
    input  logic [REG_W-1:0]  exm_src2,
    input  logic [DATA_W-1:0] exm_pc,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic [3:0]        mw_wb,
    output logic [DATA_W-1:0] mw_mem_data,
    output logic [DATA_W-1:0] mw_alu,
    output logic [REG_W-1:0]  mw_dst,
    output logic [DATA_W-1:0] mw_pc,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              access;
    logic              fwd;
    logic [DATA_W-1:0] store_val;
    logic              load_done;

    logic              lat_we;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // The registered Halt bit in MEM/WB blocks the very next instruction.
    // Holding HALT keeps the block quiesced after the Halt has moved on
    // through MEM/WB.
    assign halted = (state == HALT) | mw_wb[0];

    assign access    = (exm_mem_rd | exm_mem_wr) & ~halted;
    assign fwd       = exm_mem_wr & wb_regwrite & (wb_dst == exm_src2) & (wb_dst != '0);
    assign store_val = fwd ? wb_data : exm_store;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // A Halt can reach MEM/WB only on a non-stalling edge, so it is never
    // observed while WAIT holds a request; only IDLE needs to look for it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mw_wb[0]) begin
                    state_nxt = HALT;
                end else if (access & ~dmem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_nxt = IDLE;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // The request is gated with rst so that asserting reset mid-transaction
    // drops it at once. It does not wait for EX/MEM to be cleared.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        case (state)
            IDLE: begin
                dmem_req   = access & ~rst;
                dmem_we    = exm_mem_wr;
                dmem_addr  = exm_alu;
                dmem_wdata = store_val;
            end
            WAIT: begin
                dmem_req   = ~rst;
                dmem_we    = lat_we;
                dmem_addr  = lat_addr;
                dmem_wdata = lat_wdata;
            end
            default: begin
                dmem_req   = 1'b0;
            end
        endcase
    end

    assign mem_stall = dmem_req & ~dmem_ready;
    assign load_done = dmem_req & dmem_ready & ~dmem_we;

    // -------------------------------------------------------------------------
    // Request latch, written only when an access has to wait
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if ((state == IDLE) && access && !dmem_ready) begin
            lat_we    <= exm_mem_wr;
            lat_addr  <= exm_alu;
            lat_wdata <= store_val;
        end
    end

    // -------------------------------------------------------------------------
    // MEM/WB register
    // -------------------------------------------------------------------------
    // EX/MEM is frozen during a stall, so the exm_* fields captured on the
    // completing edge still belong to the instruction that made the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_wb       <= '0;
            mw_mem_data <= '0;
            mw_alu      <= '0;
            mw_dst      <= '0;
            mw_pc       <= '0;
        end else if (mem_stall) begin
            mw_wb       <= '0;
            mw_mem_data <= '0;
            mw_alu      <= '0;
            mw_dst      <= '0;
            mw_pc       <= '0;
        end else begin
            mw_wb       <= exm_wb;
            mw_mem_data <= load_done ? dmem_rdata : '0;
            mw_alu      <= exm_alu;
            mw_dst      <= exm_dst;
            mw_pc       <= exm_pc;
        end
    end

    // -------------------------------------------------------------------------
    // Stall-cycle counter, saturating at all-ones
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (mem_stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_memwb.sv
module tb_mem_access_memwb;

    logic        clk;
    logic        rst;
    logic        exm_mem_rd, exm_mem_wr;
    logic [3:0]  exm_wb;
    logic [15:0] exm_alu, exm_store, exm_pc;
    logic [3:0]  exm_dst, exm_src2;
    logic        wb_regwrite;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall;
    logic [3:0]  mw_wb;
    logic [15:0] mw_mem_data, mw_alu, mw_pc;
    logic [3:0]  mw_dst;
    logic        halted;
    logic [15:0] stall_cnt;

    mem_access_memwb #(.DATA_W(16), .REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .exm_mem_rd(exm_mem_rd), .exm_mem_wr(exm_mem_wr), .exm_wb(exm_wb),
        .exm_alu(exm_alu), .exm_store(exm_store), .exm_dst(exm_dst),
        .exm_src2(exm_src2), .exm_pc(exm_pc),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall),
        .mw_wb(mw_wb), .mw_mem_data(mw_mem_data), .mw_alu(mw_alu),
        .mw_dst(mw_dst), .mw_pc(mw_pc),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wb;
        logic [15:0] mem_data;
        logic [15:0] alu;
        logic [3:0]  dst;
        logic [15:0] pc;
    } mw_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mreq_t;

    mw_t   mwq[$];
    mreq_t mq[$];

    int    n_chk  = 0;
    int    n_pass = 0;
    logic  exp_stall  = 1'b0;
    logic  exp_halted = 1'b0;
    int    model_cnt  = 0;
    logic [15:0] pc_ctr = 16'h0000;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: decoupled from the driver, pops expectations as the DUT presents them.
    always @(negedge clk) begin
        mw_t   e;
        mreq_t r;
        chk(mem_stall === exp_stall, "mem_stall", {63'd0, mem_stall}, {63'd0, exp_stall});
        chk(halted === exp_halted, "halted", {63'd0, halted}, {63'd0, exp_halted});
        if (dmem_req === 1'b1) begin
            if (mq.size() == 0) begin
                chk(1'b0, "unexpected_req", {31'd0, dmem_we, dmem_addr, dmem_wdata}, 64'd0);
            end else begin
                r = mq[0];
                chk({dmem_we, dmem_addr, dmem_wdata} === {r.we, r.addr, r.wdata}, "dmem_request",
                    {31'd0, dmem_we, dmem_addr, dmem_wdata}, {31'd0, r.we, r.addr, r.wdata});
                if (dmem_ready) void'(mq.pop_front());
            end
        end
        if (mw_pc !== 16'h0000) begin
            if (mwq.size() == 0) begin
                chk(1'b0, "unexpected_mw", {8'd0, mw_wb, mw_mem_data, mw_alu, mw_dst, mw_pc}, 64'd0);
            end else begin
                e = mwq.pop_front();
                chk({mw_wb, mw_mem_data, mw_alu, mw_dst, mw_pc} === {e.wb, e.mem_data, e.alu, e.dst, e.pc},
                    "mw_record", {8'd0, mw_wb, mw_mem_data, mw_alu, mw_dst, mw_pc},
                    {8'd0, e.wb, e.mem_data, e.alu, e.dst, e.pc});
            end
        end else begin
            chk({mw_wb, mw_mem_data, mw_alu, mw_dst} === 40'd0, "mw_bubble",
                {24'd0, mw_wb, mw_mem_data, mw_alu, mw_dst}, 64'd0);
        end
    end

    task automatic clear_exm();
        exm_mem_rd = 0; exm_mem_wr = 0; exm_wb = 0; exm_alu = 0; exm_store = 0;
        exm_dst = 0; exm_src2 = 0; exm_pc = 0;
    endtask

    // Presents one instruction in EX/MEM and plays a memory that answers after
    // 'lat' stall cycles. It must be called right after a posedge (+1).
    task automatic issue(input logic rd, input logic wr, input logic [3:0] wb,
                         input logic [15:0] alu, input logic [15:0] store,
                         input logic [3:0] dst, input logic [3:0] src2,
                         input logic wbrw, input logic [3:0] wbd, input logic [15:0] wbdata,
                         input int lat, input logic [15:0] rdata, input bit scramble);
        bit          is_mem;
        logic [15:0] sv;
        mw_t         e;
        mreq_t       r;
        pc_ctr += 16'd2;
        exm_mem_rd = rd; exm_mem_wr = wr; exm_wb = wb; exm_alu = alu; exm_store = store;
        exm_dst = dst; exm_src2 = src2; exm_pc = pc_ctr;
        wb_regwrite = wbrw; wb_dst = wbd; wb_data = wbdata;
        is_mem = (rd | wr) & ~exp_halted;
        if (is_mem) begin
            sv = (wr && wbrw && (wbd == src2) && (wbd != 4'd0)) ? wbdata : store;
            r.we = wr; r.addr = alu; r.wdata = sv;
            mq.push_back(r);
        end
        e.wb = wb; e.alu = alu; e.dst = dst; e.pc = pc_ctr;
        e.mem_data = (is_mem && rd && !wr) ? rdata : 16'h0000;
        mwq.push_back(e);
        if (is_mem) begin
            for (int k = 0; k < lat; k++) begin
                dmem_ready = 1'b0;
                exp_stall  = 1'b1;
                @(posedge clk); #1;
                if (scramble) begin
                    wb_data     = (k == 0) ? 16'h0000 : 16'($urandom);
                    wb_dst      = 4'($urandom);
                    wb_regwrite = 1'($urandom);
                end
            end
            model_cnt = (model_cnt + lat > 65535) ? 65535 : model_cnt + lat;
            dmem_ready = 1'b1;
            dmem_rdata = rdata;
        end else begin
            dmem_ready = exp_halted ? 1'b0 : 1'($urandom);
            dmem_rdata = 16'($urandom);
        end
        exp_stall = 1'b0;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        if (wb[0]) exp_halted = 1'b1;
        chk(stall_cnt == model_cnt[15:0], "stall_cnt", {48'd0, stall_cnt}, {48'd0, model_cnt[15:0]});
    endtask

    initial begin
        int rem;
        rst = 1'b1;
        clear_exm();
        wb_regwrite = 0; wb_dst = 0; wb_data = 0;
        dmem_ready = 0; dmem_rdata = 0;
        #1;
        chk({dmem_req, mem_stall, halted} === 3'b000, "reset_ctrl", {61'd0, dmem_req, mem_stall, halted}, 64'd0);
        chk({mw_wb, mw_mem_data, mw_alu, mw_dst, mw_pc, stall_cnt} === 72'd0, "reset_regs",
            {8'd0, mw_wb, mw_mem_data, mw_alu, mw_dst, mw_pc}, 64'd0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait load and a three-cycle store.
        issue(1, 0, 4'b1100, 16'h0040, 16'h0000, 4'd3, 4'd0, 0, 4'd0, 16'h0, 0, 16'hBEEF, 0);
        issue(0, 1, 4'b0000, 16'h0010, 16'h1234, 4'd0, 4'd1, 0, 4'd0, 16'h0, 3, 16'h0, 0);
        chk(stall_cnt == 16'd3, "stall_cnt_3", {48'd0, stall_cnt}, 64'd3);
        // Forwarded store, WB bus changes during the wait.
        issue(0, 1, 4'b0000, 16'h0020, 16'h1111, 4'd0, 4'd5, 1, 4'd5, 16'hA5A5, 2, 16'h0, 1);
        // No forwarding from R0.
        issue(0, 1, 4'b0000, 16'h0022, 16'h2222, 4'd0, 4'd0, 1, 4'd0, 16'hA5A5, 1, 16'h0, 0);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom), 1'($urandom), {3'($urandom), 1'b0}, 16'($urandom), 16'($urandom),
                  4'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)),
                  16'($urandom), $urandom_range(0, 4), 16'($urandom), 1);
        end

        // Saturation: bring the counter to 0xFFFE, then stall three more cycles.
        rem = 65534 - model_cnt;
        issue(1, 0, 4'b1000, 16'h0100, 16'h0, 4'd2, 4'd0, 0, 4'd0, 16'h0, rem, 16'h5A5A, 0);
        chk(stall_cnt == 16'hFFFE, "stall_cnt_fffe", {48'd0, stall_cnt}, 64'hFFFE);
        issue(0, 1, 4'b0000, 16'h0102, 16'h7777, 4'd0, 4'd1, 0, 4'd0, 16'h0, 3, 16'h0, 0);
        chk(stall_cnt == 16'hFFFF, "stall_cnt_sat", {48'd0, stall_cnt}, 64'hFFFF);

        // Reset during WAIT.
        pc_ctr += 16'd2;
        exm_mem_rd = 0; exm_mem_wr = 1; exm_wb = 0; exm_alu = 16'h0300; exm_store = 16'hCAFE;
        exm_dst = 0; exm_src2 = 4'd1; exm_pc = pc_ctr; wb_regwrite = 0;
        begin
            mreq_t r;
            r.we = 1; r.addr = 16'h0300; r.wdata = 16'hCAFE;
            mq.push_back(r);
        end
        exp_stall = 1'b1; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1; exp_stall = 1'b0; mq.delete();
        #1;
        chk({dmem_req, mem_stall} === 2'b00, "rst_wait_req", {62'd0, dmem_req, mem_stall}, 64'd0);
        chk({mw_wb, mw_mem_data, mw_alu, mw_dst, mw_pc} === 56'd0, "rst_wait_mw",
            {8'd0, mw_wb, mw_mem_data, mw_alu, mw_dst, mw_pc}, 64'd0);
        chk(stall_cnt === 16'd0, "rst_wait_cnt", {48'd0, stall_cnt}, 64'd0);
        clear_exm();
        model_cnt = 0;
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        issue(1, 0, 4'b1100, 16'h0444, 16'h0, 4'd6, 4'd0, 0, 4'd0, 16'h0, 0, 16'h4321, 0);

        // Halt, then a load that must never reach the memory.
        issue(0, 0, 4'b0001, 16'h0000, 16'h0, 4'd0, 4'd0, 0, 4'd0, 16'h0, 0, 16'h0, 0);
        issue(1, 0, 4'b1100, 16'h0050, 16'h0, 4'd7, 4'd0, 0, 4'd0, 16'h0, 2, 16'h9999, 0);
        issue(0, 1, 4'b0000, 16'h0052, 16'h1, 4'd0, 4'd0, 0, 4'd0, 16'h0, 2, 16'h0, 0);
        issue(0, 0, 4'b1000, 16'h0AAA, 16'h0, 4'd4, 4'd0, 0, 4'd0, 16'h0, 0, 16'h0, 0);

        clear_exm();
        repeat (3) @(posedge clk);
        #1;
        chk(mwq.size() == 0, "mw_queue_drained", 64'(mwq.size()), 64'd0);
        chk(mq.size() == 0, "req_queue_drained", 64'(mq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
